sram_access_sequencer: RTL
==========================

// Module: sram_access_sequencer
// PURPOSE
//  Top-level phase sequencer and SRAM access multiplexer for the image decompressor.
//  Steps the design through UART load, Milestone 1, Milestone 2 and VGA display.
//  Grants the single SRAM port to exactly one requester per phase: UART, M1, M2 or VGA.
//  Issues one-cycle start pulses and waits on done pulses.
// PARAMETERS
//  UART_TIMEOUT  50000000  idle cycles after last UART write that end a file load (1 s @ 50 MHz)
//  SKIP_UART     0         1: IDLE goes straight to M1 after IDLE_SKIP cycles (simulation use)
//  IDLE_SKIP     16        cycles spent in IDLE before the skip when SKIP_UART=1
// PORTS
//  Clock               in   1   50 MHz clock
//  Reset               in   1   synchronous, active-high reset
//  UART_start          in   1   RX line low or PB0 pushed (level, sampled in IDLE/DISPLAY)
//  UART_SRAM_address   in   18  UART write address
//  UART_SRAM_write_data in  16  UART write data
//  UART_SRAM_we_n      in   1   UART write strobe, active low
//  M1_SRAM_address     in   18  / M1_SRAM_write_data in 16 / M1_SRAM_we_n in 1
//  M2_SRAM_address     in   18  / M2_SRAM_write_data in 16 / M2_SRAM_we_n in 1
//  VGA_SRAM_address    in   18  VGA read address
//  M1_done, M2_done    in   1   one-cycle completion pulses
//  UART_initialize     out  1   one-cycle pulse: clear UART address/state
//  UART_enable         out  1   one-cycle pulse: arm UART receiver
//  M1_start, M2_start  out  1   one-cycle start pulses
//  VGA_enable          out  1   VGA fetch enable
//  SRAM_address        out  18  muxed SRAM address
//  SRAM_write_data     out  16  muxed SRAM write data
//  SRAM_we_n           out  1   muxed write strobe, active low
//  state_code          out  3   current state encoding (drives LEDs)
// BEHAVIOUR
//  States and encodings:
//   IDLE=0, UART_INIT=1, UART_WAIT=2, M1_START=3, M1_WAIT=4, M2_START=5, M2_WAIT=6, DISPLAY=7.
//  Reset (sync): state=IDLE; timer=0; VGA_enable=1; all pulse outputs 0.
//   Reset applies from any state, including mid-phase; a requester in progress is simply ungranted.
//  Timer (26 bit):
//   - Cleared on any cycle with UART_initialize=1 or UART_SRAM_we_n=0.
//   - Otherwise increments and saturates at all-ones.
//  IDLE / DISPLAY: VGA_enable=1.
//   - UART_start=1: pulse UART_initialize, VGA_enable<=0, go to UART_INIT.
//   - IDLE only, SKIP_UART=1 and timer==IDLE_SKIP-1 (UART_start=0): go to M1_START.
//   - If both conditions hold in the same cycle, UART_start wins.
//  UART_INIT: pulse UART_enable, go to UART_WAIT.
//  UART_WAIT: when timer==UART_TIMEOUT-1 and UART_SRAM_address!=0:
//   - pulse UART_initialize, go to M1_START.
//   - With address==0 (no data received), stay indefinitely.
//  M1_START: pulse M1_start, go to M1_WAIT. M1_WAIT: on M1_done go to M2_START.
//  M2_START: pulse M2_start, go to M2_WAIT. M2_WAIT: on M2_done set VGA_enable<=1, go to DISPLAY.
//  Done pulses are honoured only in the matching WAIT state; all other done pulses are ignored.
//  All pulse outputs are registered, high for exactly one cycle, and asserted in the cycle after the transition decision.
//  SRAM mux: combinational from registered state (0-cycle latency from the requester inputs).
//   - UART_INIT/UART_WAIT -> UART signals; M1_START/M1_WAIT -> M1; M2_START/M2_WAIT -> M2.
//   - IDLE/DISPLAY -> VGA_SRAM_address, SRAM_write_data=0, SRAM_we_n=1.
//   - SRAM_we_n is 1 in every state whose requester is not granted.
//   - A non-granted requester never reaches SRAM.
// TESTING (bench uses UART_TIMEOUT=100)
//  1. Reset held 2 cycles in M1_WAIT -> state_code=0, VGA_enable=1, SRAM_we_n=1, M1_start=0.
//  2. UART_start pulse in IDLE -> UART_initialize=1 for 1 cycle, then UART_enable=1 for 1 cycle, state_code=2;
//     UART writes at addr 0..9 -> SRAM mirrors UART signals; 100 idle cycles -> UART_initialize pulse, state_code=3.
//  3. UART_WAIT with UART_SRAM_address=0 for 300 cycles -> state stays 2, no M1_start.
//  4. SKIP_UART=1, no stimulus -> M1_START entered on cycle 16 after reset release; M1_start high exactly 1 cycle.
//  5. M1_done in M1_START and M2_done in M1_WAIT -> ignored; M1_done in M1_WAIT -> M2_start pulse;
//     M2_done -> state_code=7, VGA_enable=1, SRAM_address==VGA_SRAM_address.
//  6. M1_WAIT with M1_SRAM_we_n=0 at addr 18'h3FFFF and UART_SRAM_we_n=0 -> SRAM_address=3FFFF, UART write blocked.

Source files
------------

// File: rtl/sram_access_sequencer.sv
// Phase sequencer for the image decompressor: UART load, M1, M2, VGA display.
// Owns the single SRAM port and grants it to exactly one requester per phase.
module sram_access_sequencer #(
   parameter int unsigned UART_TIMEOUT = 50000000,
   parameter bit          SKIP_UART    = 1'b0,
   parameter int unsigned IDLE_SKIP    = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        UART_start,
   input  logic [17:0] UART_SRAM_address,
   input  logic [15:0] UART_SRAM_write_data,
   input  logic        UART_SRAM_we_n,
   input  logic [17:0] M1_SRAM_address,
   input  logic [15:0] M1_SRAM_write_data,
   input  logic        M1_SRAM_we_n,
   input  logic [17:0] M2_SRAM_address,
   input  logic [15:0] M2_SRAM_write_data,
   input  logic        M2_SRAM_we_n,
   input  logic [17:0] VGA_SRAM_address,
   input  logic        M1_done,
   input  logic        M2_done,
   output logic        UART_initialize,
   output logic        UART_enable,
   output logic        M1_start,
   output logic        M2_start,
   output logic        VGA_enable,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic [2:0]  state_code
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_UART_INIT = 3'd1,
      S_UART_WAIT = 3'd2,
      S_M1_START  = 3'd3,
      S_M1_WAIT   = 3'd4,
      S_M2_START  = 3'd5,
      S_M2_WAIT   = 3'd6,
      S_DISPLAY   = 3'd7
   } state_t;

   localparam logic [25:0] TIMEOUT_LAST = 26'(UART_TIMEOUT - 1);
   localparam logic [25:0] SKIP_LAST    = 26'(IDLE_SKIP - 1);

   state_t      state;
   logic [25:0] timer;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state           <= S_IDLE;
         timer           <= '0;
         VGA_enable      <= 1'b1;
         UART_initialize <= 1'b0;
         UART_enable     <= 1'b0;
         M1_start        <= 1'b0;
         M2_start        <= 1'b0;
      end else begin
         UART_initialize <= 1'b0;
         UART_enable     <= 1'b0;
         M1_start        <= 1'b0;
         M2_start        <= 1'b0;

         // Timer measures idle time since the last UART write; saturates so it never wraps back into a match
         if (UART_initialize || !UART_SRAM_we_n) timer <= '0;
         else if (timer != '1)                   timer <= timer + 26'd1;

         case (state)
            S_IDLE, S_DISPLAY: begin
               if (UART_start) begin
                  UART_initialize <= 1'b1;
                  VGA_enable      <= 1'b0;
                  state           <= S_UART_INIT;
               end else if (state == S_IDLE && SKIP_UART && timer == SKIP_LAST) begin
                  state <= S_M1_START;
               end
            end
            S_UART_INIT: begin
               UART_enable <= 1'b1;
               state       <= S_UART_WAIT;
            end
            S_UART_WAIT: begin
               if (timer == TIMEOUT_LAST && UART_SRAM_address != '0) begin
                  UART_initialize <= 1'b1;
                  state           <= S_M1_START;
               end
            end
            S_M1_START: begin
               M1_start <= 1'b1;
               state    <= S_M1_WAIT;
            end
            S_M1_WAIT: begin
               if (M1_done) state <= S_M2_START;
            end
            S_M2_START: begin
               M2_start <= 1'b1;
               state    <= S_M2_WAIT;
            end
            S_M2_WAIT: begin
               if (M2_done) begin
                  VGA_enable <= 1'b1;
                  state      <= S_DISPLAY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      SRAM_address    = VGA_SRAM_address;
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
      case (state)
         S_UART_INIT, S_UART_WAIT: begin
            SRAM_address    = UART_SRAM_address;
            SRAM_write_data = UART_SRAM_write_data;
            SRAM_we_n       = UART_SRAM_we_n;
         end
         S_M1_START, S_M1_WAIT: begin
            SRAM_address    = M1_SRAM_address;
            SRAM_write_data = M1_SRAM_write_data;
            SRAM_we_n       = M1_SRAM_we_n;
         end
         S_M2_START, S_M2_WAIT: begin
            SRAM_address    = M2_SRAM_address;
            SRAM_write_data = M2_SRAM_write_data;
            SRAM_we_n       = M2_SRAM_we_n;
         end
         default: ;
      endcase
   end

   assign state_code = state;

endmodule
